// File: rtl/cim_link_pkg.sv
// Shared types for the CIM inter-layer link: FSM state encoding and a width helper.
package cim_link_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } link_state_t;

  // Counter width for a 0..x-1 range; never narrower than one bit so x = 1 still works.
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/func_ibuf_bridge.sv
// Serial activation to parallel per-channel ibuf write bridge with pixel/frame counting.
// Optional macro FUNC_IBUF_RELU_EN: clamp negative activations to zero on capture.
module func_ibuf_bridge
  import cim_link_pkg::*;
#(
  parameter int channels      = 96,
  parameter int img_width     = 55,
  parameter int datatype_size = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [datatype_size-1:0] i_data,
  output logic                     o_busy,
  input  logic                     i_ds_busy,
  output logic                     o_ibuf_we      [channels],
  output logic [datatype_size-1:0] o_ibuf_wr_data [channels],
  output logic                     o_frame_done
);

  localparam int FRAME_PX = img_width * img_width;
  localparam int CH_W     = safe_clog2(channels);
  localparam int PX_W     = safe_clog2(FRAME_PX);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(channels - 1);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(FRAME_PX - 1);

  // Handshake: one activation moves when i_valid && !o_busy at a rising edge.
  // o_busy is purely the registered HOLD state, so it never depends on i_valid.

  link_state_t              state;
  logic [CH_W-1:0]          ch_cnt;
  logic [PX_W-1:0]          px_cnt;
  logic [datatype_size-1:0] shadow [channels];
  logic [datatype_size-1:0] cap_data;
  logic                     accept;
  logic                     drain;

  assign o_busy = (state == HOLD);
  assign accept = i_valid && !o_busy;
  assign drain  = o_busy && !i_ds_busy;

  always_comb begin
    cap_data = i_data;
`ifdef FUNC_IBUF_RELU_EN
    if (i_data[datatype_size-1]) cap_data = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= COLLECT;
      ch_cnt       <= '0;
      px_cnt       <= '0;
      o_frame_done <= 1'b0;
      for (int c = 0; c < channels; c++) begin
        shadow[c]         <= '0;
        o_ibuf_we[c]      <= 1'b0;
        o_ibuf_wr_data[c] <= '0;
      end
    end else begin
      // Write strobes are single-cycle; data registers keep the last pixel.
      o_frame_done <= 1'b0;
      for (int c = 0; c < channels; c++) o_ibuf_we[c] <= 1'b0;

      if (accept) begin
        shadow[ch_cnt] <= cap_data;
        if (ch_cnt == CH_LAST) begin
          ch_cnt <= '0;
          state  <= HOLD;
        end else begin
          ch_cnt <= ch_cnt + CH_W'(1);
        end
      end

      if (drain) begin
        for (int c = 0; c < channels; c++) begin
          o_ibuf_we[c]      <= 1'b1;
          o_ibuf_wr_data[c] <= shadow[c];
        end
        state <= COLLECT;
        if (px_cnt == PX_LAST) begin
          px_cnt       <= '0;
          o_frame_done <= 1'b1;
        end else begin
          px_cnt <= px_cnt + PX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_func_ibuf_bridge.sv
// Bench for func_ibuf_bridge: directed scenarios with literal write checks plus a
// random phase, all compared every cycle against a queue-based pixel model.
module tb_func_ibuf_bridge;

  localparam int CH    = 4;
  localparam int IW    = 2;
  localparam int DS    = 2;
  localparam int FRAME = IW * IW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [DS-1:0] i_data = '0;
  logic          i_ds_busy = 1'b0;
  logic          o_busy;
  logic          o_ibuf_we [CH];
  logic [DS-1:0] o_ibuf_wr_data [CH];
  logic          o_frame_done;

  func_ibuf_bridge #(.channels(CH), .img_width(IW), .datatype_size(DS)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .o_busy(o_busy),
    .i_ds_busy(i_ds_busy), .o_ibuf_we(o_ibuf_we), .o_ibuf_wr_data(o_ibuf_wr_data),
    .o_frame_done(o_frame_done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DS-1:0] relu(input logic [DS-1:0] v);
`ifdef FUNC_IBUF_RELU_EN
    return v[DS-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  // exp_q holds the activations of the pixel being assembled; a full pixel moves
  // to m_pixel and the model is "holding" until downstream takes it.
  logic [DS-1:0]      exp_q[$];
  logic [DS-1:0]      m_pixel [CH];
  bit                 m_hold = 0;
  int                 m_px = 0;
  bit                 started = 0;
  logic               exp_we = 0;
  logic               exp_fd = 0;
  logic [CH*DS-1:0]   exp_data = '0;

  always @(posedge clk) begin
    started = 1;
    exp_we  = 0;
    exp_fd  = 0;
    if (rst) begin
      exp_q.delete();
      m_hold   = 0;
      m_px     = 0;
      exp_data = '0;
    end else if (!m_hold) begin
      if (i_valid) exp_q.push_back(relu(i_data));
      if (exp_q.size() == CH) begin
        for (int c = 0; c < CH; c++) m_pixel[c] = exp_q[c];
        exp_q.delete();
        m_hold = 1;
      end
    end else if (!i_ds_busy) begin
      exp_we = 1;
      for (int c = 0; c < CH; c++) exp_data[c*DS +: DS] = m_pixel[c];
      exp_fd = (m_px == FRAME - 1);
      m_px   = (m_px + 1) % FRAME;
      m_hold = 0;
    end
  end

  // ---------------- compare + write log ----------------
  logic [CH*DS-1:0] wr_log[$];
  bit               fd_log[$];

  function automatic logic [CH*DS-1:0] pack_data();
    logic [CH*DS-1:0] p;
    for (int c = 0; c < CH; c++) p[c*DS +: DS] = o_ibuf_wr_data[c];
    return p;
  endfunction

  function automatic logic [CH-1:0] pack_we();
    logic [CH-1:0] p;
    for (int c = 0; c < CH; c++) p[c] = o_ibuf_we[c];
    return p;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      check("busy", 64'(o_busy), 64'(m_hold));
      check("we", 64'(pack_we()), exp_we ? 64'({CH{1'b1}}) : 64'd0);
      check("frame_done", 64'(o_frame_done), 64'(exp_fd));
      check("wr_data", 64'(pack_data()), 64'(exp_data));
      if (o_ibuf_we[0]) begin
        wr_log.push_back(pack_data());
        fd_log.push_back(o_frame_done);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles, input logic valid_during);
    rst = 1; i_valid = valid_during; i_data = DS'($urandom_range(0, 3));
    repeat (cycles) @(posedge clk);
    #1 rst = 0; i_valid = 0;
  endtask

  task automatic send(input logic [DS-1:0] v);
    bit b;
    int n = 0;
    i_valid = 1; i_data = v;
    forever begin
      b = o_busy;
      @(posedge clk); #1;
      if (!b) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    i_valid = 0;
    i_data  = DS'($urandom_range(0, 3));
  endtask

  task automatic send_pixel(input logic [DS-1:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic idle(input int n);
    i_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with i_valid asserted: outputs must stay quiet.
    do_reset(3, 1'b1);
    @(negedge clk);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_we", 64'(pack_we()), 64'd0);
    check("rst_data", 64'(pack_data()), 64'd0);
    check("rst_fd", 64'(o_frame_done), 64'd0);
    @(posedge clk); #1;

    // Single pixel 1,1,0,1 back-to-back.
    wr_log.delete(); fd_log.delete();
    send_pixel(2'd1, 2'd1, 2'd0, 2'd1);
    check("sp_busy_after_last", 64'(o_busy), 64'd1);
    check("sp_no_we_yet", 64'(wr_log.size()), 64'd0);
    @(posedge clk); #1;
    check("sp_we", 64'(pack_we()), 64'hF);
    check("sp_busy_low", 64'(o_busy), 64'd0);
    check("sp_data", 64'(pack_data()), 64'h45);
    idle(2);

    // Backpressure: downstream busy while upstream keeps offering 3.
    do_reset(1, 1'b0);
    wr_log.delete(); fd_log.delete();
    i_ds_busy = 1;
    send_pixel(2'd1, 2'd0, 2'd1, 2'd1);
    i_valid = 1; i_data = 2'd3;
    repeat (5) @(posedge clk);
    #1;
    check("bp_no_write", 64'(wr_log.size()), 64'd0);
    check("bp_busy_held", 64'(o_busy), 64'd1);
    i_ds_busy = 0; i_valid = 0;
    idle(3);
    check("bp_one_write", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() > 0) check("bp_data", 64'(wr_log[0]), 64'h51);

    // Frame boundary: five pixels, frame_done only with the fourth write.
    do_reset(1, 1'b0);
    wr_log.delete(); fd_log.delete();
    for (int p = 0; p < 5; p++) begin
      send_pixel(DS'($urandom_range(0, 3)), DS'($urandom_range(0, 3)),
                 DS'($urandom_range(0, 3)), DS'($urandom_range(0, 3)));
      idle($urandom_range(1, 3));
    end
    check("fr_writes", 64'(wr_log.size()), 64'd5);
    if (fd_log.size() == 5) begin
      check("fr_fd_pattern", 64'({fd_log[4], fd_log[3], fd_log[2], fd_log[1], fd_log[0]}),
            64'b01000);
    end

    // Negative-value handling.
    do_reset(1, 1'b0);
    wr_log.delete(); fd_log.delete();
    send_pixel(2'd2, 2'd1, 2'd3, 2'd0);
    idle(2);
    check("relu_writes", 64'(wr_log.size()), 64'd1);
`ifdef FUNC_IBUF_RELU_EN
    if (wr_log.size() > 0) check("relu_data", 64'(wr_log[0]), 64'h04);
`else
    if (wr_log.size() > 0) check("relu_data", 64'(wr_log[0]), 64'h36);
`endif

    // Mid-pixel reset discards the partial pixel.
    do_reset(1, 1'b0);
    wr_log.delete(); fd_log.delete();
    send(2'd3); send(2'd3);
    do_reset(1, 1'b0);
    send_pixel(2'd1, 2'd0, 2'd1, 2'd0);
    idle(3);
    check("mr_writes", 64'(wr_log.size()), 64'd1);
    if (wr_log.size() > 0) check("mr_data", 64'(wr_log[0]), 64'h11);

    // Random traffic, including occasional resets, checked by the model.
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst       = ($urandom_range(0, 99) == 0);
      i_valid   = ($urandom_range(0, 3) != 0);
      i_data    = DS'($urandom_range(0, 3));
      i_ds_busy = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
    end
    rst = 0; i_valid = 0; i_ds_busy = 0;
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
